// File: rtl/draw_tom.sv
// Tom sprite overlay stage. Computes the Tom ROM address for each incoming pixel,
// merges the returned colour over the background (skipping the transparency key)
// and delays the VGA timing signals so the output bus stays aligned with the
// one-cycle ROM round trip. Total latency is 3 clk.
module draw_tom #(
  parameter int unsigned WIDTH     = 50,
  parameter int unsigned HEIGHT    = 100,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mirror,
  input  logic        enable,
  output logic [19:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Frame shadow registers
  logic [11:0] x_s_q, y_s_q;
  logic        mirror_s_q, en_s_q, vblnk_prev_q;
  logic        latch;

  // Stage 0 combinational results
  logic [11:0] hc_ext, vc_ext;
  logic [12:0] x_end, y_end;
  logic [11:0] col_raw, col, row;
  logic        in_sprite;
  logic [19:0] addr_d;

  // Stage 1 / 2 / 3 pipeline registers
  logic [19:0] addr_q;
  logic        hit1_q, hs1_q, vs1_q, hb1_q, vb1_q;
  logic [10:0] hc1_q, vc1_q;
  logic [11:0] rgb1_q;
  logic        hit2_q, hs2_q, vs2_q, hb2_q, vb2_q;
  logic [10:0] hc2_q, vc2_q;
  logic [11:0] rgb2_q;
  logic        hs3_q, vs3_q, hb3_q, vb3_q;
  logic [10:0] hc3_q, vc3_q;
  logic [11:0] rgb3_q, rgb_d;

  assign latch = vblnk_in & ~vblnk_prev_q;

  // Capture sprite parameters on the vblnk rising edge so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_s_q        <= '0;
      y_s_q        <= '0;
      mirror_s_q   <= 1'b0;
      en_s_q       <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (latch) begin
        x_s_q      <= xpos;
        y_s_q      <= ypos;
        mirror_s_q <= mirror;
        en_s_q     <= enable;
      end
    end
  end

  // Hit test and ROM address for the current pixel
  always_comb begin
    hc_ext  = {1'b0, hcount_in};
    vc_ext  = {1'b0, vcount_in};
    // 13-bit right/bottom bounds so a corner near 4095 cannot wrap
    x_end   = {1'b0, x_s_q} + 13'(WIDTH);
    y_end   = {1'b0, y_s_q} + 13'(HEIGHT);
    in_sprite = en_s_q
              & (hc_ext >= x_s_q) & ({1'b0, hc_ext} < x_end)
              & (vc_ext >= y_s_q) & ({1'b0, vc_ext} < y_end)
              & ~hblnk_in & ~vblnk_in;
    col_raw = hc_ext - x_s_q;
    row     = vc_ext - y_s_q;
    col     = mirror_s_q ? (12'(WIDTH - 1) - col_raw) : col_raw;
    addr_d  = '0;
    if (in_sprite) begin
      addr_d = 20'(row) * 20'(WIDTH) + 20'(col);
    end
  end

  // Stage 1: issue ROM address, register hit flag and pixel stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      hit1_q <= 1'b0;
      hc1_q  <= '0;
      vc1_q  <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      hb1_q  <= 1'b0;
      vb1_q  <= 1'b0;
      rgb1_q <= '0;
    end else begin
      addr_q <= addr_d;
      hit1_q <= in_sprite;
      hc1_q  <= hcount_in;
      vc1_q  <= vcount_in;
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      hb1_q  <= hblnk_in;
      vb1_q  <= vblnk_in;
      rgb1_q <= rgb_in;
    end
  end

  // Stage 2: wait for the ROM read to complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit2_q <= 1'b0;
      hc2_q  <= '0;
      vc2_q  <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      hb2_q  <= 1'b0;
      vb2_q  <= 1'b0;
      rgb2_q <= '0;
    end else begin
      hit2_q <= hit1_q;
      hc2_q  <= hc1_q;
      vc2_q  <= vc1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      hb2_q  <= hb1_q;
      vb2_q  <= vb1_q;
      rgb2_q <= rgb1_q;
    end
  end

  // Colour merge: sprite pixel wins unless it is the transparency key
  always_comb begin
    rgb_d = rgb2_q;
    if (hit2_q && (rom_data != KEY_COLOR)) begin
      rgb_d = rom_data;
    end
  end

  // Stage 3: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc3_q  <= '0;
      vc3_q  <= '0;
      hs3_q  <= 1'b0;
      vs3_q  <= 1'b0;
      hb3_q  <= 1'b0;
      vb3_q  <= 1'b0;
      rgb3_q <= '0;
    end else begin
      hc3_q  <= hc2_q;
      vc3_q  <= vc2_q;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      hb3_q  <= hb2_q;
      vb3_q  <= vb2_q;
      rgb3_q <= rgb_d;
    end
  end

  assign rom_addr   = addr_q;
  assign hcount_out = hc3_q;
  assign vcount_out = vc3_q;
  assign hsync_out  = hs3_q;
  assign vsync_out  = vs3_q;
  assign hblnk_out  = hb3_q;
  assign vblnk_out  = vb3_q;
  assign rgb_out    = rgb3_q;

endmodule

// File: tb/tb_draw_tom.sv
// Self-checking bench for draw_tom: directed scenarios plus randomized frames
// compared against a pixel-level reference model of the sprite overlay.
module tb_draw_tom;

  localparam int W = 50;
  localparam int H = 100;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        mirror, enable;
  logic [19:0] rom_addr;
  logic [11:0] rom_data;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_tom #(.WIDTH(W), .HEIGHT(H), .KEY_COLOR(KEY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .rgb_in    (rgb_in),
    .xpos      (xpos),
    .ypos      (ypos),
    .mirror    (mirror),
    .enable    (enable),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hblnk_out (hblnk_out),
    .vblnk_out (vblnk_out),
    .rgb_out   (rgb_out)
  );

  always #5 clk = ~clk;

  // Tom ROM: registered read, one cycle after the address
  logic [11:0] mem [0:4999];
  always @(posedge clk) rom_data <= (rom_addr < 20'd5000) ? mem[int'(rom_addr)] : 12'h000;

  typedef struct {
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [19:0] addr;
  } exp_t;

  exp_t q[$];
  int   m_x, m_y;
  bit   m_mir, m_en, m_prev;
  int   checks = 0;
  int   errors = 0;

  task automatic model_reset();
    exp_t z;
    z = '{hc: '0, vc: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0, addr: '0};
    m_x = 0; m_y = 0; m_mir = 0; m_en = 0; m_prev = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  // Drive one pixel, record the model's expectation, advance one clock.
  task automatic drive(input int h, input int v, input bit hb, input bit vb,
                       input logic [11:0] rgb);
    exp_t e;
    int   col, addr;
    bit   hit;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    hit  = m_en && h >= m_x && h < m_x + W && v >= m_y && v < m_y + H && !hb && !vb;
    col  = m_mir ? (m_x + W - 1 - h) : (h - m_x);
    addr = hit ? (v - m_y) * W + col : 0;
    e.hc = hcount_in; e.vc = vcount_in; e.hs = hsync_in; e.vs = vsync_in;
    e.hb = hb; e.vb = vb;
    e.rgb  = (hit && mem[addr] !== KEY) ? mem[addr] : rgb;
    e.addr = 20'(addr);
    if (vb && !m_prev) begin
      m_x = int'(xpos); m_y = int'(ypos); m_mir = mirror; m_en = enable;
    end
    m_prev = vb;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b1, 1'b0, 12'(i));
  endtask

  task automatic latch();
    flush();
    drive(0, 0, 1'b1, 1'b1, 12'h000);
    drive(0, 0, 1'b1, 1'b1, 12'h000);
    drive(0, 0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hcount_in = 11'($urandom); vcount_in = 11'($urandom); rgb_in = 12'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
      xpos = 12'($urandom); ypos = 12'($urandom);
      mirror = 1'($urandom); enable = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
           rom_addr} !== '0) begin
        errors++;
        $display("FAIL reset_zero: got rgb=%h addr=%h hc=%h vc=%h, required all zero",
                 rgb_out, rom_addr, hcount_out, vcount_out);
      end
    end
    model_reset();
    xpos = 12'd0; ypos = 12'd0; enable = 1'b1; mirror = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(10 + i, 10, 1'b0, 1'b0, 12'($urandom));
      e = q[q.size() - 3];
      checks++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}
          !== {e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}) begin
        errors++;
        $display("FAIL reset_timing: got %h/%h %b%b%b%b, required %h/%h %b%b%b%b",
                 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 e.hc, e.vc, e.hs, e.vs, e.hb, e.vb);
      end
      checks++;
      if (rgb_out !== e.rgb || rom_addr !== 20'd0) begin
        errors++;
        $display("FAIL reset_pass: got rgb=%h addr=%0d, required rgb=%h addr=0",
                 rgb_out, rom_addr, e.rgb);
      end
    end
  endtask

  task automatic test_basic_draw();
    int ph [6] = '{100, 149, 100, 149, 150, 100};
    int pv [6] = '{50, 50, 51, 149, 50, 150};
    int ea [6] = '{0, 49, 50, 4999, 0, 0};
    logic [11:0] rv [8];
    logic [11:0] want;
    for (int i = 0; i < 5000; i++) mem[i] = 12'h123;
    xpos = 12'd100; ypos = 12'd50; enable = 1'b1; mirror = 1'b0;
    latch();
    for (int i = 0; i < 8; i++) begin
      rv[i] = 12'($urandom);
      if (i < 6) drive(ph[i], pv[i], 1'b0, 1'b0, rv[i]);
      else drive(0, 0, 1'b1, 1'b0, rv[i]);
      if (i < 6) begin
        checks++;
        if (rom_addr !== 20'(ea[i])) begin
          errors++;
          $display("FAIL basic_addr: pixel (%0d,%0d) got %0d, required %0d",
                   ph[i], pv[i], rom_addr, ea[i]);
        end
      end
      if (i >= 2) begin
        want = (i - 2 < 4) ? 12'h123 : rv[i - 2];
        checks++;
        if (rgb_out !== want) begin
          errors++;
          $display("FAIL basic_rgb: pixel %0d got %h, required %h", i - 2, rgb_out, want);
        end
      end
    end
  endtask

  task automatic test_mirror();
    int ph [3] = '{100, 149, 125};
    int pv [3] = '{50, 50, 60};
    int ea [3] = '{49, 0, 524};
    mirror = 1'b1;
    latch();
    for (int i = 0; i < 3; i++) begin
      drive(ph[i], pv[i], 1'b0, 1'b0, 12'($urandom));
      checks++;
      if (rom_addr !== 20'(ea[i])) begin
        errors++;
        $display("FAIL mirror_addr: pixel (%0d,%0d) got %0d, required %0d",
                 ph[i], pv[i], rom_addr, ea[i]);
      end
    end
  endtask

  task automatic test_transparency();
    logic [11:0] rv [6];
    logic [11:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      flush();
      for (int i = 0; i < 5000; i++) mem[i] = (pass == 0) ? 12'hF0F : 12'hF0E;
      for (int i = 0; i < 6; i++) begin
        rv[i] = 12'($urandom);
        if (i < 4) drive(100 + 7 * i, 55 + i, 1'b0, 1'b0, rv[i]);
        else drive(0, 0, 1'b1, 1'b0, rv[i]);
        if (i >= 2) begin
          want = (pass == 0) ? rv[i - 2] : 12'hF0E;
          checks++;
          if (rgb_out !== want) begin
            errors++;
            $display("FAIL transparency: pass %0d got %h, required %h", pass, rgb_out, want);
          end
        end
      end
    end
  endtask

  task automatic test_frame_latch();
    int ph [7] = '{120, 120, 100, 300, 300, 120, 150};
    int pv [7] = '{60, 60, 61, 61, 62, 62, 70};
    int ea [7] = '{520, 520, 550, 0, 600, 0, 0};
    mirror = 1'b0; xpos = 12'd100; ypos = 12'd50; enable = 1'b1;
    latch();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) xpos = 12'd300;
      if (i == 4) latch();
      if (i == 6) begin enable = 1'b0; latch(); end
      drive(ph[i], pv[i], 1'b0, 1'b0, 12'($urandom));
      checks++;
      if (rom_addr !== 20'(ea[i])) begin
        errors++;
        $display("FAIL frame_latch_addr: step %0d got %0d, required %0d", i, rom_addr, ea[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive(300 + int'($urandom_range(0, 49)), 50 + int'($urandom_range(0, 99)), 1'b0, 1'b0,
            12'($urandom));
      checks++;
      if (rom_addr !== 20'd0 || rgb_out !== q[q.size() - 3].rgb) begin
        errors++;
        $display("FAIL disabled: got addr=%0d rgb=%h, required addr=0 rgb=%h",
                 rom_addr, rgb_out, q[q.size() - 3].rgb);
      end
    end
  endtask

  task automatic test_edge();
    int want;
    flush();
    for (int i = 0; i < 5000; i++) mem[i] = 12'(i);
    xpos = 12'd780; ypos = 12'd10; enable = 1'b1; mirror = 1'b0;
    latch();
    for (int h = 770; h < 816; h++) begin
      drive(h, 10, h >= 800, 1'b0, 12'($urandom));
      want = (h >= 780 && h < 800) ? h - 780 : 0;
      checks++;
      if (rom_addr !== 20'(want)) begin
        errors++;
        $display("FAIL edge_addr: h=%0d got %0d, required %0d", h, rom_addr, want);
      end
      checks++;
      if (rgb_out !== q[q.size() - 3].rgb) begin
        errors++;
        $display("FAIL edge_rgb: h=%0d got %h, required %h", h, rgb_out, q[q.size() - 3].rgb);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   h, v;
    for (int f = 0; f < 5; f++) begin
      flush();
      for (int i = 0; i < 5000; i++)
        mem[i] = ($urandom_range(0, 9) == 0) ? KEY : 12'($urandom);
      xpos = 12'($urandom_range(0, 900)); ypos = 12'($urandom_range(0, 700));
      mirror = 1'($urandom); enable = ($urandom_range(0, 3) != 0);
      latch();
      for (int i = 0; i < 400; i++) begin
        if (i == 200) begin
          xpos = 12'($urandom_range(0, 900)); ypos = 12'($urandom_range(0, 700));
          mirror = 1'($urandom); enable = 1'($urandom);
        end
        h = m_x + int'($urandom_range(0, W + 20)) - 10;
        v = m_y + int'($urandom_range(0, H + 20)) - 10;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        drive(h, v, $urandom_range(0, 19) == 0, 1'b0, 12'($urandom));
        e = q[q.size() - 3];
        checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}
            !== {e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, e.rgb}) begin
          errors++;
          $display("FAIL random_out: frame %0d px %0d got %h/%h rgb=%h, required %h/%h rgb=%h",
                   f, i, hcount_out, vcount_out, rgb_out, e.hc, e.vc, e.rgb);
        end
        checks++;
        if (rom_addr !== q[$].addr) begin
          errors++;
          $display("FAIL random_addr: frame %0d px %0d got %0d, required %0d",
                   f, i, rom_addr, q[$].addr);
        end
      end
    end
  endtask

  // Reset pulsed mid-frame: the sprite must stay hidden until the next latch.
  task automatic test_reset_midframe();
    xpos = 12'd200; ypos = 12'd200; enable = 1'b1; mirror = 1'b0;
    latch();
    drive(210, 210, 1'b0, 1'b0, 12'h000);
    rst_n = 1'b0;
    #2;
    checks++;
    if (rgb_out !== 12'h000 || rom_addr !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: got rgb=%h addr=%0d, required 0", rgb_out, rom_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(205 + i, 220, 1'b0, 1'b0, 12'($urandom));
      checks++;
      if (rom_addr !== 20'd0 || rgb_out !== q[q.size() - 3].rgb) begin
        errors++;
        $display("FAIL reset_hidden: got addr=%0d rgb=%h, required addr=0 rgb=%h",
                 rom_addr, rgb_out, q[q.size() - 3].rgb);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 5000; i++) mem[i] = 12'h000;
    test_reset();
    test_basic_draw();
    test_mirror();
    test_transparency();
    test_frame_latch();
    test_edge();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_tom.md
# draw_tom

Sprite overlay stage that draws the Tom character onto the VGA pixel stream. It sits between the background/timing chain and the display output. For every pixel it computes the 20-bit address into the Tom ROM (50×100 pixels, 12-bit RGB, one-cycle registered read). It then merges the returned colour over the incoming pixel, skipping a transparency key. All VGA timing signals pass through with a delay matched to the ROM round trip, so the output bus stays aligned.

## Interface

- WIDTH, 50: sprite width in pixels.
- HEIGHT, 100: sprite height in pixels; WIDTH*HEIGHT must not exceed ROM depth (5000).
- KEY_COLOR, 12'hF0F: ROM colour treated as transparent.

- clk  in  1  pixel clock; everything sampled on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hcount_in, vcount_in  in  11 each  current pixel coordinates.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
- rgb_in  in  12  background pixel, RRRRGGGGBBBB.
- xpos, ypos  in  12 each  sprite top-left corner, unsigned screen coordinates.
- mirror  in  1  1 = draw horizontally flipped (Tom facing left).
- enable  in  1  0 = sprite hidden; pixel stream passes through unchanged.
- rom_addr  out  20  address to Tom ROM; registered.
- rom_data  in  12  ROM output, valid one cycle after rom_addr.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  match inputs  delayed/merged pixel stream.

## Operation

- Frame latch: xpos, ypos, mirror and enable are captured into shadow registers on the cycle where vblnk_in is 1 and was 0 the previous cycle. The shadow copies are used for the entire following frame, so the sprite never tears mid-frame. On reset the shadow registers and the previous-vblnk register clear to 0, so the sprite is hidden until the first latch.
- Hit test (stage 0, combinational on inputs, 12-bit arithmetic with hcount/vcount zero-extended):
  - in_sprite = en_s & hcount_in ≥ x_s & hcount_in < x_s+WIDTH & vcount_in ≥ y_s & vcount_in < y_s+HEIGHT & ~hblnk_in & ~vblnk_in.
  - x_s+WIDTH is computed in 13 bits so that x_s near 4095 cannot wrap.
- Address: col = hcount_in−x_s and row = vcount_in−y_s. With mirror_s set, col = WIDTH−1−col. addr = row*WIDTH + col, range 0…WIDTH*HEIGHT−1. When in_sprite = 0, rom_addr is driven to 0.
- Stage 1: register rom_addr, the in_sprite flag and all input signals.
- Stage 2: the ROM returns data. Register the stage-1 signals again and pass rom_data combinationally into the stage-3 mux.
- Stage 3 (output register): rgb_out = rom_data if hit2 = 1 and rom_data ≠ KEY_COLOR, otherwise rgb2. All other outputs are the delayed copies.
- Sprite partially off the right or bottom of the active area: only the visible pixels are drawn, and addresses stay in range. Coordinates beyond 4095−WIDTH are not supported and no wrap to the left edge occurs.
- Changing xpos, ypos, mirror or enable mid-frame has no effect until the next vblnk rising edge.

## Timing

- Latency is 3 clk from input to the *_out signals. rom_addr is 1 clk after its input pixel. The rom_data used is the value present 2 clk after the input pixel.
- Throughput is one pixel per clk. There is no stall or handshake.
- Reset value of every output is 0, including rom_addr and rgb_out. The pipeline registers and the shadow latch also clear to 0.
- Deasserting rst_n mid-frame: output becomes valid 3 clk after release. The sprite stays hidden until the next vblnk rising edge.
- Simultaneous vblnk rising edge and a position change: the value sampled on that cycle is latched.

## Test plan

- Reset: hold rst_n=0 with random inputs. Every output must be 0. Release, then feed 3 pixels. Outputs must follow the inputs with 3-cycle delay, unchanged.
- Basic draw: xpos=100, ypos=50, enable=1, latched at vblnk. At pixel (100,50), rom_addr=0 one cycle later. At (149,50), rom_addr=49. At (100,51), rom_addr=50. At (149,149), rom_addr=4999. ROM model returns 12'h123, so rgb_out=12'h123 exactly 3 cycles after each of those pixels. At (150,50) and (100,150), rgb_out=rgb_in.
- Mirror: same position with mirror=1. At (100,50), rom_addr=49. At (149,50), rom_addr=0.
- Transparency: ROM model returns 12'hF0F inside the sprite, so rgb_out equals the delayed rgb_in. ROM returns 12'hF0E, so rgb_out=12'hF0E.
- Frame latch and enable: change xpos from 100 to 300 at the middle of line 60. The remainder of the frame still draws at x=100, and the next frame draws at x=300. With enable=0 latched, no pixel is altered and rom_addr stays 0.
- Edge/blanking: xpos=780 on an 800-wide active area. Only columns 780–799 are drawn, with addresses 0–19 on the first row. No hit and rom_addr=0 while hblnk_in=1.
